// File: rtl/max_reduce_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : max_reduce_ctrl_pkg
// Brief    : Shared state encoding and tree latency for the max-reduce block.
// Revision : 1.0
// ============================================================================
package max_reduce_ctrl_pkg;

    localparam int TREE_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/max_32.sv
`default_nettype none
// ============================================================================
// Module   : max_32
// Brief    : Two-stage pipelined signed maximum over 32 elements (unreset).
// Revision : 1.0
// ============================================================================
module max_32 #(
    parameter int DATA_WIDTH = 9
) (
    input  logic                         clk,
    input  logic signed [DATA_WIDTH-1:0] in_data [0:31],
    output logic signed [DATA_WIDTH-1:0] out_data
);

    logic signed [DATA_WIDTH-1:0] w_l1 [0:15];
    logic signed [DATA_WIDTH-1:0] w_l2 [0:7];
    logic signed [DATA_WIDTH-1:0] w_l3 [0:3];
    logic signed [DATA_WIDTH-1:0] w_l4 [0:1];
    logic signed [DATA_WIDTH-1:0] mid_d [0:3];
    logic signed [DATA_WIDTH-1:0] mid_q [0:3];
    logic signed [DATA_WIDTH-1:0] out_d;
    logic signed [DATA_WIDTH-1:0] out_q;

    // Stage 1: 32 -> 4 before the first register
    for (genvar i = 0; i < 16; i++) begin : g_l1
        assign w_l1[i] = (in_data[2*i] > in_data[2*i+1]) ? in_data[2*i] : in_data[2*i+1];
    end
    for (genvar i = 0; i < 8; i++) begin : g_l2
        assign w_l2[i] = (w_l1[2*i] > w_l1[2*i+1]) ? w_l1[2*i] : w_l1[2*i+1];
    end
    for (genvar i = 0; i < 4; i++) begin : g_l3
        assign w_l3[i] = (w_l2[2*i] > w_l2[2*i+1]) ? w_l2[2*i] : w_l2[2*i+1];
    end

    // Stage 2: 4 -> 1 before the output register
    for (genvar i = 0; i < 2; i++) begin : g_l4
        assign w_l4[i] = (mid_q[2*i] > mid_q[2*i+1]) ? mid_q[2*i] : mid_q[2*i+1];
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mid_d[i] = w_l3[i];
        end
        out_d = (w_l4[0] > w_l4[1]) ? w_l4[0] : w_l4[1];
    end

    always_ff @(posedge clk) begin
        mid_q <= mid_d;
        out_q <= out_d;
    end

    assign out_data = out_q;

endmodule
`default_nettype wire

// File: rtl/max_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : max_reduce_ctrl
// Brief    : Streams beats through max_32 and tracks the running max and index.
// Revision : 1.0
// ============================================================================
module max_reduce_ctrl
    import max_reduce_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int LANES      = 32,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             num_chunks,
    input  logic                         abort,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data [0:LANES-1],
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic signed [DATA_WIDTH-1:0] res_data,
    output logic [CNT_W-1:0]             res_idx
);

    localparam logic signed [DATA_WIDTH-1:0] c_ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             num_q, num_d;
    logic [CNT_W-1:0]             snd_q, snd_d;
    logic [CNT_W-1:0]             rcv_q, rcv_d;
    logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]             idx_q, idx_d;
    logic [TREE_LAT-1:0]          vpipe_q, vpipe_d;
    logic signed [DATA_WIDTH-1:0] w_tree_out;
    logic                         w_fire;

    max_32 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_max_32 (
        .clk      (clk),
        .in_data  (in_data),
        .out_data (w_tree_out)
    );

    assign w_fire = in_valid && (state_q == ST_FEED);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        snd_d   = snd_q;
        rcv_d   = rcv_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        vpipe_d = {vpipe_q[TREE_LAT-2:0], w_fire};

        case (state_q)
            ST_IDLE: begin
                if (start && (num_chunks != '0)) begin
                    num_d   = num_chunks;
                    snd_d   = '0;
                    rcv_d   = '0;
                    acc_d   = c_ACC_MIN;
                    idx_d   = '0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (w_fire) begin
                    snd_d = snd_q + CNT_W'(1);
                    if (snd_q == num_q - CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Beats return in order, so the receive count is the beat index
        if (vpipe_q[TREE_LAT-1] && (state_q == ST_FEED || state_q == ST_DRAIN)) begin
            rcv_d = rcv_q + CNT_W'(1);
            if (w_tree_out > acc_q) begin
                acc_d = w_tree_out;
                idx_d = rcv_q;
            end
            if (state_q == ST_DRAIN && (rcv_q + CNT_W'(1)) == num_q) begin
                state_d = ST_DONE;
            end
        end

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            vpipe_d = '0;
            acc_d   = acc_q;
            idx_d   = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            snd_q   <= '0;
            rcv_q   <= '0;
            acc_q   <= c_ACC_MIN;
            idx_q   <= '0;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            snd_q   <= snd_d;
            rcv_q   <= rcv_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            vpipe_q <= vpipe_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_FEED);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = acc_q;
    assign res_idx   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_max_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_reduce_ctrl
// Brief    : Directed self-checking bench for max_reduce_ctrl.
// Revision : 1.0
// ============================================================================
module tb_max_reduce_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        num_chunks;
    logic              abort;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic signed [8:0] in_data [0:31];
    logic              res_valid;
    logic              res_ready;
    logic signed [8:0] res_data;
    logic [7:0]        res_idx;

    int n_vec = 0;
    int n_bad = 0;
    int lat;

    max_reduce_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_chunks (num_chunks),
        .abort      (abort),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_idx    (res_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_beat(input logic signed [8:0] mx, input int lane, input logic signed [8:0] other);
        for (int i = 0; i < 32; i++) in_data[i] = other;
        in_data[lane] = mx;
    endtask

    task automatic start_red(input logic [7:0] n);
        start      = 1'b1;
        num_chunks = n;
        tick();
        start      = 1'b0;
    endtask

    // Optional idle gap, then one beat presented for exactly one FEED cycle
    task automatic send_beat(input logic signed [8:0] mx, input int lane, input logic signed [8:0] other, input bit gap);
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        set_beat(mx, lane, other);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called in the cycle after the last fire; returns cycles from fire to res_valid
    task automatic wait_result(output int l);
        l = 1;
        while (!res_valid && l < 20) begin
            tick();
            l++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_chunks = '0; abort = 1'b0;
        in_valid = 1'b0; res_ready = 1'b0;
        set_beat(9'sd0, 0, 9'sd0);
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, -256);
        chk("rst_res_idx", res_idx, 0);
        rst = 1'b0;
        tick();

        // Single beat, lane 5 carries the max, in_valid held
        start_red(8'd1);
        chk("t1_in_ready", in_ready, 1);
        set_beat(9'sd100, 5, -9'sd3);
        in_valid = 1'b1;
        tick();
        chk("t1_drain_in_ready", in_ready, 0);
        wait_result(lat);
        in_valid = 1'b0;
        chk("t1_latency", lat, 3);
        chk("t1_data", res_data, 100);
        chk("t1_idx", res_idx, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1_res_valid_clr", res_valid, 0);
        chk("t1_busy_clr", busy, 0);

        // Four beats with gaps; tie on 42 must keep beat 2
        start_red(8'd4);
        send_beat(9'sd10, 3, -9'sd100, 1'b1);
        send_beat(-9'sd7, 31, -9'sd100, 1'b1);
        send_beat(9'sd42, 0, -9'sd100, 1'b1);
        send_beat(9'sd42, 17, -9'sd100, 1'b1);
        wait_result(lat);
        chk("t2_latency", lat, 3);
        chk("t2_data", res_data, 42);
        chk("t2_idx", res_idx, 2);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // All elements at the most negative value
        start_red(8'd3);
        set_beat(-9'sd256, 0, -9'sd256);
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        wait_result(lat);
        chk("t3_latency", lat, 3);
        chk("t3_data", res_data, -256);
        chk("t3_idx", res_idx, 0);

        // Hold off res_ready in DONE; start there is ignored
        for (int i = 0; i < 5; i++) begin
            start      = (i == 2);
            num_chunks = 8'd1;
            tick();
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_data", res_data, -256);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t4_idle_after_hs", busy, 0);
        start_red(8'd1);
        chk("t4_restart_busy", busy, 1);
        chk("t4_restart_ready", in_ready, 1);

        // Abort one cycle after the last fire: no result, acc untouched
        send_beat(9'sd77, 9, 9'sd1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_result", res_valid, 0);
        end
        chk("t5_acc_untouched", res_data, -256);
        start_red(8'd1);
        send_beat(-9'sd1, 12, -9'sd50, 1'b0);
        wait_result(lat);
        chk("t5_next_latency", lat, 3);
        chk("t5_next_data", res_data, -1);
        chk("t5_next_idx", res_idx, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset while draining
        start_red(8'd2);
        set_beat(9'sd60, 4, 9'sd5);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        chk("t6_in_drain", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_res_valid", res_valid, 0);
        chk("t6_res_data", res_data, -256);
        chk("t6_res_idx", res_idx, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_stale", res_valid, 0);
        end
        chk("t6_acc_after_rst", res_data, -256);
        start_red(8'd0);
        chk("t6_zero_start", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/max_reduce_ctrl.md
MAX_REDUCE_CTRL -- requirements
Module: max_reduce_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, signed element width.
REQ-002 SHALL have parameter LANES, default 32, elements per beat; fixed to the 32-input tree width.
REQ-003 SHALL have parameter CNT_W, default 8, width of chunk count and index.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a reduction.
REQ-007 SHALL have port num_chunks  input  CNT_W  beats in the reduction, sampled with start.
REQ-008 SHALL have port abort  input  1  cancels an in-flight reduction.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port in_valid  input  1  in_data beat valid.
REQ-011 SHALL have port in_ready  output  1  controller accepts a beat.
REQ-012 SHALL have port in_data  input  LANES x DATA_WIDTH signed unpacked array [0:LANES-1]  beat payload.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  consumer takes the result.
REQ-015 SHALL have port res_data  output  DATA_WIDTH signed  maximum over all accepted elements.
REQ-016 SHALL have port res_idx  output  CNT_W  zero-based beat index holding res_data.

Function
REQ-017 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-018 IDLE: start=1 with num_chunks!=0 SHALL latch num_chunks, clear counters, set acc to -2^(DATA_WIDTH-1), set acc_idx to 0, and go to FEED; start with num_chunks=0 SHALL be ignored.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 in_ready SHALL equal 1 only in FEED; a beat fires on in_valid&&in_ready; each fire increments the send counter.
REQ-021 The fire of beat num_chunks-1 SHALL move FEED->DRAIN in the same edge; no further beats are accepted.
REQ-022 The valid pipe SHALL be 2 flops alongside the tree: vpipe[0]<=fire, vpipe[1]<=vpipe[0]; tree output is valid in cycle T+2 for a fire in cycle T.
REQ-023 When vpipe[1]=1: acc and acc_idx SHALL be updated iff tree_out > acc (signed, strict); on ties the earliest beat index is kept; the receive counter increments.
REQ-024 DRAIN->DONE SHALL occur on the edge where the receive counter reaches num_chunks.
REQ-025 Result latency: last fire in cycle T SHALL give res_valid=1 in cycle T+3.
REQ-026 DONE: res_valid=1 and res_data/res_idx SHALL stay stable until res_ready=1; the handshake edge SHALL go to IDLE with res_valid=0 next cycle.
REQ-027 abort=1 in FEED/DRAIN/DONE SHALL go to IDLE next edge, clear vpipe, and produce no result; abort in IDLE has no effect; abort wins over every other event.
REQ-028 Back-to-back: start in the cycle after leaving DONE SHALL be accepted; results from a prior reduction SHALL never update acc after abort.

Reset
REQ-029 rst SHALL force state IDLE, vpipe=0, counters=0, acc=-2^(DATA_WIDTH-1), acc_idx=0.
REQ-030 Output reset values SHALL be busy=0, in_ready=0, res_valid=0, res_data=-2^(DATA_WIDTH-1), res_idx=0.
REQ-031 rst mid-operation SHALL discard all in-flight tree data; the tree datapath itself is unreset and is qualified only by vpipe.

Structure
REQ-032 A shared package SHALL hold the state enum type and the TREE_LAT=2 constant.
REQ-033 The block SHALL instantiate max_32 as its single sub-module, with DATA_WIDTH passed through.
REQ-034 Outputs SHALL be registered or decoded directly from the state register; no combinational path from in_valid to in_ready.

Verification
REQ-035 num_chunks=1, beat with lane 5=100, others -3, in_valid held -> res_valid 3 cycles after fire, res_data=100, res_idx=0.
REQ-036 num_chunks=4, beat maxima 10,-7,42,42 with in_valid gaps -> res_data=42, res_idx=2 (tie keeps earliest).
REQ-037 All elements -256 (W=9), num_chunks=3 -> res_data=-256, res_idx=0.
REQ-038 res_ready held low 5 cycles in DONE -> res_valid and data stable; start during DONE ignored; start after return to IDLE accepted.
REQ-039 abort one cycle after the last fire -> IDLE, no res_valid; the next reduction of num_chunks=1 with max -1 -> res_data=-1.
REQ-040 rst asserted in DRAIN -> all outputs at reset values next cycle; start with num_chunks=0 -> busy stays 0.
